// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the CAM controller and its benches.
//   cam_op_e    - command opcode encoding (WRITE/READ/SEARCH/FILL)
//   cam_state_e - controller state encoding
//   clogb2()    - ceiling log2, used to size address and counter fields
package cam_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_READ   = 2'b01,
    OP_SEARCH = 2'b10,
    OP_FILL   = 2'b11
  } cam_op_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SET    = 3'd1,
    WR_HOLD   = 3'd2,
    RD_WAIT   = 3'd3,
    SRCH      = 3'd4,
    FILL_SET  = 3'd5,
    FILL_HOLD = 3'd6,
    RESP      = 3'd7
  } cam_state_e;

  // Number of bits needed to index 'value' items; never less than 1.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cam_ctrl_if.sv
// cam_ctrl_if: command/response bus between a requester and cam_ctrl.
//   cmd_valid/cmd_ready - command handshake; cmd_op, cmd_addr, cmd_data,
//                         cmd_key, cmd_mask, cmd_col - command operands
//   rsp_valid/rsp_ready - response handshake; rsp_data, rsp_op - payload
//   master modport: requester side; slave modport: controller side.
interface cam_ctrl_if #(
  parameter int WORD_SIZE = 8,
  parameter int AW        = 9
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [AW-1:0]        cmd_addr;
  logic [WORD_SIZE-1:0] cmd_data;
  logic [WORD_SIZE-1:0] cmd_key;
  logic [WORD_SIZE-1:0] cmd_mask;
  logic                 cmd_col;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_SIZE-1:0] rsp_data;
  logic [1:0]           rsp_op;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_key, cmd_mask, cmd_col,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_op
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_key, cmd_mask, cmd_col,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_op
  );
endinterface

// File: rtl/cam_ctrl_cnt.sv
// cam_ctrl_cnt: loadable up-counter with terminal flag.
//   clk, rst  - clock, synchronous active-high reset
//   load      - load count with load_val and capture limit
//   load_val  - start value; limit - terminal value
//   en        - increment count
//   count     - current value; term - high while count equals captured limit
module cam_ctrl_cnt #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic [CW-1:0] limit,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          term
);

  logic [CW-1:0] limit_q;

  // Count register with load priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= {CW{1'b0}};
      limit_q <= {CW{1'b0}};
    end else if (load) begin
      count   <= load_val;
      limit_q <= limit;
    end else if (en) begin
      count   <= count + CW'(1);
    end else begin
      count   <= count;
    end
  end

  assign term = (count == limit_q);

endmodule

// File: rtl/cam_ctrl.sv
// cam_ctrl: sequences WRITE / READ / SEARCH / FILL commands onto a CAM port.
//   CLK100MHZ - clock (rising edge); rst - synchronous active-high reset
//   bus       - cam_ctrl_if slave: command in, response out
//   busy      - high whenever the controller is not idle
//   cam_addr, cam_col, cam_dina, cam_key, cam_mask, cam_wea - registered CAM
//               drive; cam_doutb - CAM read data
// Every cam_* output and response field is registered from the next state,
// so each output changes on the same edge the FSM enters the matching state.
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512,
  parameter int READ_LAT   = 1,
  parameter int SEARCH_CYC = 1,
  parameter int AW         = clogb2(CELL_QUANT)
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst,
  cam_ctrl_if.slave            bus,
  output logic                 busy,
  output logic [AW-1:0]        cam_addr,
  output logic                 cam_col,
  output logic [WORD_SIZE-1:0] cam_dina,
  output logic [WORD_SIZE-1:0] cam_key,
  output logic [WORD_SIZE-1:0] cam_mask,
  output logic                 cam_wea,
  input  logic [WORD_SIZE-1:0] cam_doutb
);

  // Zero-cycle waits are stretched to one so the counter always terminates.
  localparam int RL      = (READ_LAT < 1) ? 1 : READ_LAT;
  localparam int SC      = (SEARCH_CYC < 1) ? 1 : SEARCH_CYC;
  localparam int CNT_MAX = (CELL_QUANT > RL) ? ((CELL_QUANT > SC) ? CELL_QUANT : SC)
                                             : ((RL > SC) ? RL : SC);
  localparam int CW      = clogb2(CNT_MAX + 1);

  cam_state_e    state;
  cam_state_e    state_next;
  cam_op_e       op;
  logic          accept;
  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic [CW-1:0] cnt_limit;
  logic          cnt_en;
  logic [CW-1:0] cnt_count;
  logic          cnt_term;

  assign accept = (state == IDLE) && bus.cmd_valid;

  // One counter serves read latency, search hold time and FILL cell count;
  // it starts at 1 so count == cells written when a FILL terminates.
  cam_ctrl_cnt #(.CW(CW)) u_cnt (
    .clk      (CLK100MHZ),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .limit    (cnt_limit),
    .en       (cnt_en),
    .count    (cnt_count),
    .term     (cnt_term)
  );

  // Next-state and counter control.
  always_comb begin
    state_next   = state;
    cnt_load     = 1'b0;
    cnt_load_val = CW'(1);
    cnt_limit    = CW'(1);
    cnt_en       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          cnt_load = 1'b1;
          case (cam_op_e'(bus.cmd_op))
            OP_WRITE:  state_next = WR_SET;
            OP_READ: begin
              state_next = RD_WAIT;
              cnt_limit  = CW'(RL);
            end
            OP_SEARCH: begin
              state_next = SRCH;
              cnt_limit  = CW'(SC);
            end
            OP_FILL: begin
              // Cells from cmd_addr up to the last cell, no wrap.
              state_next = FILL_SET;
              cnt_limit  = CW'(CELL_QUANT) - CW'(bus.cmd_addr);
            end
            default:   state_next = IDLE;
          endcase
        end else begin
          state_next = IDLE;
        end
      end
      WR_SET:  state_next = WR_HOLD;
      WR_HOLD: state_next = RESP;
      RD_WAIT, SRCH: begin
        if (cnt_term) begin
          state_next = RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      FILL_SET: state_next = FILL_HOLD;
      FILL_HOLD: begin
        if (cnt_term) begin
          state_next = RESP;
        end else begin
          cnt_en     = 1'b1;
          state_next = FILL_SET;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus status outputs derived from the next state.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      bus.cmd_ready <= 1'b1;
    end else begin
      state         <= state_next;
      busy          <= (state_next != IDLE);
      bus.cmd_ready <= (state_next == IDLE);
    end
  end

  // CAM port drive; wea follows the SET states so it can never be high on
  // two consecutive cycles (every SET is followed by a HOLD).
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      cam_wea  <= 1'b0;
      cam_addr <= {AW{1'b0}};
      cam_dina <= {WORD_SIZE{1'b0}};
      cam_key  <= {WORD_SIZE{1'b0}};
      cam_mask <= {WORD_SIZE{1'b0}};
      cam_col  <= 1'b0;
    end else begin
      cam_wea <= (state_next == WR_SET) || (state_next == FILL_SET);
      if (accept) begin
        cam_col <= bus.cmd_col;
        if (cam_op_e'(bus.cmd_op) == OP_SEARCH) begin
          cam_key  <= bus.cmd_key;
          cam_mask <= bus.cmd_mask;
        end else begin
          cam_addr <= bus.cmd_addr;
          if (cam_op_e'(bus.cmd_op) != OP_READ) begin
            cam_dina <= bus.cmd_data;
          end else begin
            cam_dina <= cam_dina;
          end
        end
      end else if ((state == FILL_HOLD) && (state_next == FILL_SET)) begin
        cam_addr <= cam_addr + AW'(1);
      end else begin
        cam_addr <= cam_addr;
      end
    end
  end

  // Opcode latch and response registers, held stable throughout RESP.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      op            <= OP_WRITE;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= {WORD_SIZE{1'b0}};
      bus.rsp_op    <= 2'b00;
    end else begin
      if (accept) begin
        op <= cam_op_e'(bus.cmd_op);
      end else begin
        op <= op;
      end
      if ((state != RESP) && (state_next == RESP)) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_op    <= op;
        case (op)
          OP_READ:  bus.rsp_data <= cam_doutb;
          OP_FILL:  bus.rsp_data <= WORD_SIZE'(cnt_count);
          default:  bus.rsp_data <= {WORD_SIZE{1'b0}};
        endcase
      end else if ((state == RESP) && (state_next == IDLE)) begin
        bus.rsp_valid <= 1'b0;
      end else begin
        bus.rsp_valid <= bus.rsp_valid;
      end
    end
  end

endmodule

// File: doc/cam_ctrl.md
CAM_CTRL -- requirements
Module: cam_ctrl

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, 8, CAM word width; CELL_QUANT, 512, number of CAM cells; READ_LAT, 1, cycles from cam_addr stable to cam_doutb valid; SEARCH_CYC, 1, cycles key/mask held per search; AW, clogb2(CELL_QUANT), address width.
REQ-002 CLK100MHZ in 1: sole clock, rising edge.
REQ-003 rst in 1: synchronous, active-high reset.
REQ-004 cmd_valid in 1 / cmd_ready out 1: command handshake; transfer on the cycle both are high.
REQ-005 cmd_op in 2: 00 WRITE, 01 READ, 10 SEARCH, 11 FILL.
REQ-006 cmd_addr in AW, cmd_data in WORD_SIZE, cmd_key in WORD_SIZE, cmd_mask in WORD_SIZE, cmd_col in 1: command operands.
REQ-007 rsp_valid out 1 / rsp_ready in 1: response handshake; rsp_data out WORD_SIZE, rsp_op out 2 (echo of cmd_op).
REQ-008 busy out 1: high whenever state is not IDLE.
REQ-009 CAM side: cam_addr out AW, cam_col out 1, cam_dina out WORD_SIZE, cam_key out WORD_SIZE, cam_mask out WORD_SIZE, cam_wea out 1, cam_doutb in WORD_SIZE.

Function
REQ-010 States SHALL be IDLE, WR_SET, WR_HOLD, RD_WAIT, SRCH, FILL_SET, FILL_HOLD, RESP.
REQ-011 cmd_ready SHALL be high only in IDLE; operands SHALL be latched on acceptance.
REQ-012 All cam_* outputs SHALL be registered.
REQ-013 WRITE: WR_SET drives cam_wea=1 with cam_addr/cam_dina for exactly one cycle; WR_HOLD drives cam_wea=0 with addr/dina unchanged for one cycle; then RESP with rsp_data=0.
REQ-014 READ: cam_addr driven, cam_wea=0; RD_WAIT counts READ_LAT cycles; cam_doutb sampled on the last RD_WAIT cycle into rsp_data; then RESP.
REQ-015 SEARCH: cam_key/cam_mask driven for SEARCH_CYC cycles in SRCH, cam_wea=0; then RESP with rsp_data=0.
REQ-016 FILL: writes cmd_data to every address from cmd_addr through CELL_QUANT-1, each via FILL_SET (wea=1, one cycle) + FILL_HOLD (wea=0, one cycle), address counter +1 per pair; no wrap-around to 0.
REQ-017 FILL with cmd_addr=CELL_QUANT-1 SHALL write exactly one cell; rsp_data SHALL carry the count of cells written, truncated to WORD_SIZE bits.
REQ-018 Every accepted command SHALL produce exactly one response; RESP holds rsp_valid, rsp_data, rsp_op stable until rsp_ready, then returns to IDLE.
REQ-019 cam_wea SHALL never be high on two consecutive cycles.
REQ-020 cam_key, cam_mask, cam_col SHALL retain last driven value between commands; cam_col updates on every accepted command.
REQ-021 cmd_valid while busy SHALL be ignored (no latch, no loss of in-flight command).

Reset
REQ-022 rst SHALL force IDLE on the next edge regardless of state, abandoning any command with no response.
REQ-023 Reset values: cmd_ready=1 after reset; rsp_valid=0, rsp_data=0, rsp_op=0, busy=0, cam_wea=0, cam_addr=0, cam_dina=0, cam_key=0, cam_mask=0, cam_col=0, internal counters=0.
REQ-024 rst asserted mid-FILL SHALL drop cam_wea to 0 on the same edge.

Structure
REQ-025 Opcode encodings and state encoding SHALL live in a shared package cam_pkg, reused by the CAM top and benches.
REQ-026 clogb2 SHALL be a package function, not redefined locally.
REQ-027 One sub-module cam_ctrl_cnt (loadable up-counter with terminal flag) SHALL serve the READ_LAT/SEARCH_CYC/FILL counting; otherwise flat.

Verification
REQ-028 WRITE addr 5 data 0xA5 -> cam_wea high one cycle with cam_addr=5, dina=0xA5 held two cycles; response op=00 data=0.
REQ-029 WRITE addr 5 0x3C then READ addr 5 (CAM model) -> rsp_data=0x3C after READ_LAT; rsp_op=01.
REQ-030 FILL addr 508 data 0x77 (CELL_QUANT=512) -> writes 508..511 only, four wea pulses never adjacent, rsp_data=4.
REQ-031 rsp_ready held low 10 cycles after READ -> rsp_valid/data stable, cmd_ready=0, second cmd_valid ignored.
REQ-032 rst asserted during third FILL pair -> next cycle cam_wea=0, busy=0, cmd_ready=1, no response.
REQ-033 SEARCH key 0xF0 mask 0x0F, SEARCH_CYC=3 -> key/mask on CAM ports three cycles, then retained; response op=10.
